fifo_rr_merge: RTL and testbench
================================

# fifo_rr_merge

Round-robin merger that drains the M per-lane FIFOs of `fifo_multi` into a single valid/ready output stream, tagging each word with its source lane. It sits directly downstream of `fifo_multi`: it drives that block's `read[]` and consumes its `empty_n[]` and `dout[]`. A one-entry registered output stage sustains one word per cycle under continuous `out_ready`.

## Interface
- `M`, default 2: number of input lanes; legal range 1..64.
- `DATA_WIDTH`, default 8: data word width.
- `ID_WIDTH`, localparam: `(M > 1) ? $clog2(M) : 1`.

Ports:
- `clk`  input  1: single clock; all state updates on its rising edge.
- `arst_n`  input  1: asynchronous, active-low reset.
- `in_empty_n`  input  1 x [0:M-1]: lane has data. Driven by `fifo_multi.empty_n`.
- `in_read`  output  1 x [0:M-1]: pop strobe to the lane. Drives `fifo_multi.read`. At most one lane asserts it per cycle.
- `in_data`  input  DATA_WIDTH x [0:M-1]: head word of each lane, valid while `in_empty_n` is high (show-ahead).
- `out_valid`  output  1: output register holds a word.
- `out_ready`  input  1: downstream accepts the word.
- `out_data`  output  DATA_WIDTH: registered word.
- `out_id`  output  ID_WIDTH: source lane of `out_data`.

## Operation
- State: the output register (`out_valid`, `out_data`, `out_id`) and the round-robin pointer `ptr` (ID_WIDTH, range 0..M-1).
- `load = !out_valid || out_ready`. When `load` is high and any `in_empty_n` is high, the block grants one lane `g`.
- Grant selection: `g` is the first lane with `in_empty_n` high, searching `ptr`, `ptr+1`, … and wrapping modulo M.
- On a grant, in the same cycle:
  - `in_read[g]` = 1, combinationally.
  - At the clock edge: `out_data <= in_data[g]`, `out_id <= g`, `out_valid <= 1`, `ptr <= (g == M-1) ? 0 : g+1`.
- If `load` is high and no lane is non-empty:
  - `out_valid <= 0`.
  - `ptr` holds its value.
  - All `in_read` stay 0.
- If `load` is low (`out_valid && !out_ready`):
  - All registers hold.
  - All `in_read` stay 0.
  - `out_data` and `out_id` remain stable until accepted.
- `in_read` is a pure function of current inputs and state. It never depends on `in_data`.
- M = 1: `ptr` and `out_id` remain 0. The block degenerates to a registered FIFO-to-stream adapter.
- Each word is transferred exactly once. No word is duplicated or dropped.

## Timing
- Reset values (asynchronous on `arst_n` low): `out_valid` = 0, `out_data` = 0, `out_id` = 0, `ptr` = 0.
- `in_read` is all-0 while `arst_n` is low, because `out_valid` = 0 and `load` = 1, but the FIFOs are also in reset with `in_empty_n` = 0.
- Reset asserted mid-transfer discards the word in the output register. `fifo_multi` is reset together with this block.
- Latency: a word at a lane head in cycle t, when granted, appears on `out_data` with `out_valid` high in cycle t+1.
- Throughput: one word per cycle while `out_ready` = 1 and at least one lane is non-empty.
- Output handshake: a transfer occurs on a cycle with `out_valid && out_ready`. A pop and an output transfer in the same cycle are legal and required (pass-through).
- Fairness: with all lanes continuously non-empty and `out_ready` = 1, grants follow 0, 1, …, M-1, 0, … A lane waits at most M-1 grants.

## Structure
- Package `fifo_rr_merge_pkg`: holds the `id_width(M)` function returning `(M > 1) ? $clog2(M) : 1`. Shared with other consumers of `fifo_multi` that tag lane IDs.
- Sub-module `rr_arbiter`:
  - Inputs: `req[0:M-1]`, `ptr`, `en`.
  - Outputs: one-hot `gnt[0:M-1]`, encoded `gnt_id`, `any`.
  - Combinational. Implemented as a double-width priority scan to handle wrap.
  - The top owns `ptr` and the output register.

## Test plan
- Reset: hold `arst_n` = 0 with random inputs. Required: `out_valid`, `out_data`, and `out_id` are all 0, and `in_read` is all 0. Release reset: the first grant goes to the lowest non-empty lane at or above 0.
- Full load, M = 4: all lanes continuously non-empty, lane k holds data 8'h10·k+n, `out_ready` = 1. Required: `out_id` sequence 0, 1, 2, 3, 0, … at one word per cycle; data in per-lane FIFO order.
- Sparse load, M = 4: only lane 2 non-empty, with `ptr` = 3. Required: grant lane 2 (wrap from 3 → 0 → 1 → 2) and `ptr` becomes 3.
- Backpressure: `out_ready` = 0 for 5 cycles with `out_valid` = 1. Required: `out_data` and `out_id` stable, no `in_read` pulses. Then `out_ready` = 1: a pop occurs the same cycle, and the next word appears at the following cycle.
- Drain: the single remaining word is accepted while all lanes are empty. Required: `out_valid` falls to 0 the next cycle and `ptr` is unchanged.
- End-to-end with `fifo_multi`, M = 2: random writes on both lanes and random `out_ready`. Required: per-lane output order equals per-lane write order, and the word count matches.

Source files
------------

// File: rtl/fifo_rr_merge_pkg.sv
// Shared helpers for blocks that tag words with a fifo_multi lane number.
// Latency: n/a (compile-time function only).
// Backpressure: n/a.
package fifo_rr_merge_pkg;

  // Lane-id width; one bit minimum so a single-lane build still has a port.
  function automatic int id_width(input int m);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: first requester at or after ptr, wrapping modulo M.
// Latency: purely combinational.
// Backpressure: en low forces gnt to zero and any low.
module rr_arbiter
  import fifo_rr_merge_pkg::*;
#(
  parameter int M = 2,
  localparam int ID_WIDTH = id_width(M)
) (
  input  logic [M-1:0]        req,
  input  logic [ID_WIDTH-1:0] ptr,
  input  logic                en,
  output logic [M-1:0]        gnt,
  output logic [ID_WIDTH-1:0] gnt_id,
  output logic                any
);

  logic [2*M-1:0] req_dbl;
  logic [2*M-1:0] win;
  logic [2*M-1:0] cand;

  // Two copies of req back to back so the wrap becomes a plain upward scan.
  assign req_dbl = {req, req};

  // Window of exactly M positions beginning at ptr inside the doubled vector.
  always_comb begin
    win = '0;
    for (int j = 0; j < 2 * M; j++) begin
      win[j] = (j >= int'(ptr)) && (j < int'(ptr) + M);
    end
  end

  assign cand = req_dbl & win;

  // Lowest set bit of the window wins; fold its position back into 0..M-1.
  always_comb begin
    logic found;
    int   idx;
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = 0;
    for (int j = 0; j < 2 * M; j++) begin
      if (cand[j] && !found) begin
        found = 1'b1;
        idx   = (j >= M) ? j - M : j;
      end
    end
    if (found && en) begin
      gnt[idx] = 1'b1;
      gnt_id   = ID_WIDTH'(idx);
    end
    any = found && en;
  end

endmodule

// File: rtl/fifo_rr_merge.sv
// Merges M show-ahead lanes into one valid/ready stream tagged with lane id.
// Latency: one cycle from grant (in_read) to out_valid; one word per cycle.
// Backpressure: output register stalls when out_valid && !out_ready; no pops then.
module fifo_rr_merge
  import fifo_rr_merge_pkg::*;
#(
  parameter int M          = 2,
  parameter int DATA_WIDTH = 8,
  localparam int ID_WIDTH  = id_width(M)
) (
  input  logic                    clk,
  input  logic                    arst_n,
  input  logic [M-1:0]            in_empty_n,
  output logic [M-1:0]            in_read,
  input  logic [M*DATA_WIDTH-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic [ID_WIDTH-1:0]     out_id
);

  logic                  load;
  logic                  any;
  logic [ID_WIDTH-1:0]   ptr;
  logic [ID_WIDTH-1:0]   ptr_nxt;
  logic [ID_WIDTH-1:0]   gnt_id;
  logic [DATA_WIDTH-1:0] gnt_data;

  // The output register can take a new word when empty or being drained now.
  assign load = !out_valid || out_ready;

  rr_arbiter #(
    .M(M)
  ) u_arb (
    .req    (in_empty_n),
    .ptr    (ptr),
    .en     (load),
    .gnt    (in_read),
    .gnt_id (gnt_id),
    .any    (any)
  );

  // One-hot mux of the granted lane's head word.
  always_comb begin
    gnt_data = '0;
    for (int k = 0; k < M; k++) begin
      if (in_read[k]) begin
        gnt_data = in_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Pointer moves to the lane after the winner so it gets lowest priority next.
  always_comb begin
    if (int'(gnt_id) == M - 1) begin
      ptr_nxt = '0;
    end else begin
      ptr_nxt = ID_WIDTH'(int'(gnt_id) + 1);
    end
  end

  // Output register and round-robin pointer; both hold while stalled.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
      ptr       <= '0;
    end else if (load) begin
      if (any) begin
        out_valid <= 1'b1;
        out_data  <= gnt_data;
        out_id    <= gnt_id;
        ptr       <= ptr_nxt;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_rr_merge.sv
// Self-checking bench for fifo_rr_merge with M=4; lanes modelled as queues.
// Latency: words popped via in_read are expected on the output one cycle later.
// Backpressure: out_ready driven per cycle (fixed patterns and random).
module tb_fifo_rr_merge;

  localparam int M  = 4;
  localparam int DW = 8;

  typedef struct packed {
    logic [1:0]    id;
    logic [DW-1:0] data;
  } exp_t;

  logic            clk;
  logic            arst_n;
  logic [M-1:0]    in_empty_n;
  logic [M-1:0]    in_read;
  logic [M*DW-1:0] in_data;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_data;
  logic [1:0]      out_id;

  logic [DW-1:0] lane_q[M][$];
  exp_t          exp_q[$];
  int            checks   = 0;
  int            errors   = 0;
  int            n_xfer   = 0;
  int            n_pushed = 0;
  int            rr_idx   = 0;
  bit            chk_rr   = 0;

  fifo_rr_merge #(
    .M          (M),
    .DATA_WIDTH (DW)
  ) dut (
    .clk        (clk),
    .arst_n     (arst_n),
    .in_empty_n (in_empty_n),
    .in_read    (in_read),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_id     (out_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit busy();
    bit b = (exp_q.size() != 0);
    for (int k = 0; k < M; k++) b |= (lane_q[k].size() != 0);
    return b;
  endfunction

  // Present lane heads; empty lanes carry junk data that must be ignored.
  task automatic drive_lanes();
    for (int k = 0; k < M; k++) begin
      in_empty_n[k] = (lane_q[k].size() != 0);
      in_data[k*DW +: DW] = (lane_q[k].size() != 0) ? lane_q[k][0] : DW'($urandom);
    end
  endtask

  // One cycle: drive at negedge, check just before posedge, then advance.
  task automatic step(input logic rdy);
    exp_t e;
    out_ready = rdy;
    drive_lanes();
    #1;
    chk("read_onehot", 32'($countones(in_read) <= 1), 1);
    chk("out_valid", out_valid, (exp_q.size() != 0));
    if (out_valid && !out_ready) begin
      chk("read_in_stall", in_read, 0);
      if (exp_q.size() != 0) begin
        chk("stall_data", out_data, exp_q[0].data);
        chk("stall_id", out_id, exp_q[0].id);
      end
    end
    if (out_valid && out_ready && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("out_data", out_data, e.data);
      chk("out_id", out_id, e.id);
      if (chk_rr) begin
        chk("rr_order", out_id, rr_idx % M);
        rr_idx++;
      end
      n_xfer++;
    end
    for (int k = 0; k < M; k++) begin
      if (in_read[k]) begin
        if (lane_q[k].size() == 0) begin
          chk("read_empty_lane", 1, 0);
        end else begin
          e.id   = 2'(k);
          e.data = lane_q[k].pop_front();
          exp_q.push_back(e);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic peek_read(input logic rdy, input logic [M-1:0] exp, input string tag);
    out_ready = rdy;
    drive_lanes();
    #1;
    chk(tag, in_read, exp);
    step(rdy);
  endtask

  task automatic drain_all();
    for (int i = 0; i < 200 && busy(); i++) step(1'b1);
    chk("drain_done", busy(), 0);
  endtask

  // Lanes are reset together with the merger, so they empty at the same time.
  task automatic do_reset();
    for (int k = 0; k < M; k++) lane_q[k].delete();
    exp_q.delete();
    drive_lanes();
    out_ready = 1'($urandom);
    arst_n = 1'b0;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_id", out_id, 0);
    chk("rst_read", in_read, 0);
    @(negedge clk);
    @(negedge clk);
    arst_n = 1'b1;
  endtask

  initial begin
    int x0;
    arst_n     = 1'b1;
    out_ready  = 1'b0;
    in_empty_n = '0;
    in_data    = '0;
    #2;
    @(negedge clk);
    do_reset();

    // First grant after reset goes to the lowest non-empty lane.
    lane_q[1].push_back(8'hA1);
    lane_q[3].push_back(8'hA3);
    peek_read(1'b1, 4'b0010, "first_grant");
    drain_all();

    // Reset while a word is held discards it.
    lane_q[0].push_back(8'h55);
    step(1'b0);
    step(1'b0);
    chk("held_before_reset", out_valid, 1);
    do_reset();

    // Full load: strict 0,1,2,3 order, one word per cycle.
    for (int k = 0; k < M; k++)
      for (int n = 0; n < 6; n++) lane_q[k].push_back(DW'(16 * k + n));
    chk_rr = 1;
    rr_idx = 0;
    x0 = n_xfer;
    repeat (25) step(1'b1);
    chk_rr = 0;
    chk("full_xfers", n_xfer - x0, 24);
    drain_all();

    // Sparse: lane 2 alone leaves ptr at 3, then lane 2 is found by wrapping.
    lane_q[2].push_back(8'hC0);
    step(1'b1);
    step(1'b1);
    lane_q[2].push_back(8'hC1);
    peek_read(1'b1, 4'b0100, "sparse_wrap");
    lane_q[0].push_back(8'hC2);
    lane_q[1].push_back(8'hC3);
    lane_q[3].push_back(8'hC4);
    peek_read(1'b1, 4'b1000, "sparse_ptr");
    drain_all();

    // Backpressure for five cycles, then release pops in the same cycle.
    for (int k = 0; k < M; k++) begin
      lane_q[k].push_back(DW'(8'hE0 + k));
      lane_q[k].push_back(DW'(8'hF0 + k));
    end
    step(1'b0);
    repeat (5) begin
      chk("bp_valid", out_valid, 1);
      step(1'b0);
    end
    out_ready = 1'b1;
    drive_lanes();
    #1;
    chk("bp_release_pop", |in_read, 1);
    step(1'b1);
    chk("bp_next_valid", out_valid, 1);
    drain_all();

    // Drain: last word leaves with all lanes empty; ptr must not move.
    lane_q[1].push_back(8'hD1);
    step(1'b1);
    step(1'b1);
    #1;
    chk("drain_valid_low", out_valid, 0);
    for (int k = 0; k < M; k++) lane_q[k].push_back(DW'(8'h90 + k));
    peek_read(1'b1, 4'b0100, "drain_ptr_hold");
    drain_all();

    // Random writes and random out_ready; scoreboard checks order and count.
    x0 = n_xfer;
    n_pushed = 0;
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < M; k++) begin
        if (lane_q[k].size() < 8 && $urandom_range(0, 2) == 0) begin
          lane_q[k].push_back(DW'($urandom));
          n_pushed++;
        end
      end
      step(1'($urandom_range(0, 3) != 0));
    end
    drain_all();
    chk("rand_count", n_xfer - x0, n_pushed);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
